// File: rtl/tuart_pkg.sv
// Shared types and helpers for the Tiny-UART receiver.
package tuart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } states_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10
    } parity_mode_t;

    // 2'b11 is not a real mode; it behaves as no parity.
    function automatic parity_mode_t decode_parity(input logic [1:0] p);
        case (p)
            2'b01:   return PAR_ODD;
            2'b10:   return PAR_EVEN;
            default: return PAR_NONE;
        endcase
    endfunction

    // data_xor is the XOR-reduction of the received data bits.
    function automatic logic parity_ok(input parity_mode_t m, input logic data_xor,
                                       input logic par_bit);
        case (m)
            PAR_ODD:  return (data_xor ^ par_bit) == 1'b1;
            PAR_EVEN: return (data_xor ^ par_bit) == 1'b0;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/tuart_rx_word.sv
// Frame-level receiver: start/data/parity/stop sequencing with a runtime
// bit-period divider. Produces one accepted word or one error pulse per frame.
module tuart_rx_word
    import tuart_pkg::*;
#(
    parameter int WORD_BITS = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    input  logic [DIV_WIDTH-1:0] clk_per_bit_i,
    input  logic [1:0]           parity_i,
    input  logic                 stop2_i,
    output logic [WORD_BITS-1:0] word_o,
    output logic                 word_vld_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 busy_o
);

    localparam int BCW = $clog2(WORD_BITS + 1);

    states_t              state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    parity_mode_t         par_q, par_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 perr_q, perr_d;
    logic [DIV_WIDTH-1:0] cmp;
    logic                 sample;

    // Next-state, sample counter and per-frame error/accept pulses.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + DIV_WIDTH'(1);
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        div_d        = div_q;
        par_d        = par_q;
        stop2_d      = stop2_q;
        stop_idx_d   = stop_idx_q;
        perr_d       = perr_q;
        word_vld_o   = 1'b0;
        frame_err_o  = 1'b0;
        parity_err_o = 1'b0;
        // Start bit is sampled half a bit in, so later samples land mid-bit.
        cmp    = (state_q == START) ? (div_q >> 1) : div_q;
        sample = (cnt_q == cmp - DIV_WIDTH'(1));
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_i) begin
                    // Config is frozen for the whole frame from here on.
                    state_d = START;
                    div_d   = clk_per_bit_i;
                    par_d   = decode_parity(parity_i);
                    stop2_d = stop2_i;
                    perr_d  = 1'b0;
                end
            end
            START: begin
                if (sample) begin
                    cnt_d = '0;
                    if (rx_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_i, shreg_q[WORD_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == BCW'(WORD_BITS - 1)) begin
                        state_d    = (par_q == PAR_NONE) ? STOP : PARITY;
                        stop_idx_d = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    cnt_d      = '0;
                    perr_d     = !parity_ok(par_q, ^shreg_q, rx_i);
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
            STOP: begin
                if (sample) begin
                    cnt_d = '0;
                    if (!rx_i) begin
                        // Frame error outranks a pending parity error.
                        frame_err_o = 1'b1;
                        state_d     = BREAK;
                    end else if (!stop2_q || stop_idx_q) begin
                        state_d = IDLE;
                        if (perr_q) parity_err_o = 1'b1;
                        else        word_vld_o   = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            BREAK: begin
                // Wait out a held-low line so it reports only one error.
                cnt_d = '0;
                if (rx_i) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            div_q      <= '0;
            par_q      <= PAR_NONE;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            div_q      <= div_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            perr_q     <= perr_d;
        end
    end

    assign word_o = shreg_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/tuart_rx_cfg.sv
// Configurable UART receiver for the SUMP command path: assembles short
// (1-word) or long (CMD_WORDS-word) commands and drops stale partial ones.
module tuart_rx_cfg
    import tuart_pkg::*;
#(
    parameter int WORD_BITS    = 8,
    parameter int CMD_WORDS    = 5,
    parameter int DIV_WIDTH    = 16,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           rx_sync_i,
    input  logic [DIV_WIDTH-1:0]           clk_per_bit_i,
    input  logic [1:0]                     parity_i,
    input  logic                           stop2_i,
    output logic [WORD_BITS*CMD_WORDS-1:0] data_o,
    output logic                           stb_o,
    output logic                           frame_err_o,
    output logic                           parity_err_o,
    output logic                           timeout_o,
    output logic                           busy_o
);

    localparam int OUT = WORD_BITS * CMD_WORDS;
    localparam int WCW = $clog2(CMD_WORDS + 1);
    localparam int TCW = $clog2(TIMEOUT_CLKS + 1);

    logic [WORD_BITS-1:0] w_word;
    logic                 w_vld, w_ferr, w_perr, w_busy;

    logic [OUT-1:0] cmd_buf_q, cmd_buf_d, buf_new;
    logic [OUT-1:0] data_q, data_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic           stb_q, stb_d, ferr_q, ferr_d, perr_q, perr_d, tmo_q, tmo_d;

    tuart_rx_word #(
        .WORD_BITS(WORD_BITS),
        .DIV_WIDTH(DIV_WIDTH)
    ) u_word (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_i         (rx_sync_i),
        .clk_per_bit_i(clk_per_bit_i),
        .parity_i     (parity_i),
        .stop2_i      (stop2_i),
        .word_o       (w_word),
        .word_vld_o   (w_vld),
        .frame_err_o  (w_ferr),
        .parity_err_o (w_perr),
        .busy_o       (w_busy)
    );

    // Command assembly, inter-word timeout and registered output strobes.
    always_comb begin
        cmd_buf_d  = cmd_buf_q;
        word_cnt_d = word_cnt_q;
        data_d     = data_q;
        tmo_cnt_d  = '0;
        stb_d      = 1'b0;
        ferr_d     = w_ferr;
        perr_d     = w_perr;
        tmo_d      = 1'b0;
        // First word lands in the most significant slot.
        buf_new = cmd_buf_q;
        for (int k = 0; k < CMD_WORDS; k++) begin
            if (word_cnt_q == WCW'(k)) buf_new[OUT-1-k*WORD_BITS -: WORD_BITS] = w_word;
        end
        if (w_ferr || w_perr) begin
            cmd_buf_d  = '0;
            word_cnt_d = '0;
        end else if (w_vld) begin
            if (word_cnt_q == '0 && !w_word[WORD_BITS-1]) begin
                stb_d                      = 1'b1;
                data_d                     = '0;
                data_d[OUT-1 -: WORD_BITS] = w_word;
                cmd_buf_d                  = '0;
                word_cnt_d                 = '0;
            end else if (word_cnt_q == WCW'(CMD_WORDS - 1)) begin
                stb_d      = 1'b1;
                data_d     = buf_new;
                cmd_buf_d  = '0;
                word_cnt_d = '0;
            end else begin
                cmd_buf_d  = buf_new;
                word_cnt_d = word_cnt_q + WCW'(1);
            end
        end else if (!w_busy && word_cnt_q != '0 && word_cnt_q < WCW'(CMD_WORDS)) begin
            // A start edge coinciding with expiry still clears, so the new
            // frame begins a fresh command.
            if (tmo_cnt_q == TCW'(TIMEOUT_CLKS - 1)) begin
                tmo_d      = 1'b1;
                cmd_buf_d  = '0;
                word_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TCW'(1);
            end
        end
    end

    // Assembly state and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_buf_q  <= '0;
            data_q     <= '0;
            word_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            stb_q      <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            cmd_buf_q  <= cmd_buf_d;
            data_q     <= data_d;
            word_cnt_q <= word_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            stb_q      <= stb_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            tmo_q      <= tmo_d;
        end
    end

    assign data_o       = data_q;
    assign stb_o        = stb_q;
    assign frame_err_o  = ferr_q;
    assign parity_err_o = perr_q;
    assign timeout_o    = tmo_q;
    assign busy_o       = w_busy;

endmodule

// File: tb/tb_tuart_rx_cfg.sv
// Scenario bench for tuart_rx_cfg: bit-bangs UART frames, queues the expected
// commands and compares them with what the receiver strobes out.
module tb_tuart_rx_cfg;

    localparam int WB  = 8;
    localparam int CW  = 5;
    localparam int DW  = 16;
    localparam int OUT = WB * CW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           rx = 1'b1;
    logic [DW-1:0]  div = 16'd10;
    logic [1:0]     par = 2'b00;
    logic           stop2 = 1'b0;
    logic [OUT-1:0] data;
    logic           stb, ferr, perr, tmo, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ferr = 0, n_perr = 0, n_tmo = 0, n_busy = 0;
    logic [OUT-1:0] exp_q[$];
    logic [OUT-1:0] got_q[$];

    tuart_rx_cfg #(
        .WORD_BITS(WB), .CMD_WORDS(CW), .DIV_WIDTH(DW), .TIMEOUT_CLKS(200)
    ) dut (
        .clk_i(clk), .rst_i(rst), .rx_sync_i(rx), .clk_per_bit_i(div),
        .parity_i(par), .stop2_i(stop2), .data_o(data), .stb_o(stb),
        .frame_err_o(ferr), .parity_err_o(perr), .timeout_o(tmo), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Monitor: collect strobed commands and count pulses away from the edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (stb) got_q.push_back(data);
            if (ferr) n_ferr++;
            if (perr) n_perr++;
            if (tmo) n_tmo++;
            if (busy) n_busy++;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        clks(int'(div));
    endtask

    task automatic send_word(input logic [7:0] w, input bit bad_par);
        logic p;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
        if (par == 2'b01 || par == 2'b10) begin
            p = (par == 2'b10) ? ^w : ~^w;
            if (bad_par) p = ~p;
            send_bit(p);
        end
        send_bit(1'b1);
        if (stop2) send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic clear_counts();
        n_ferr = 0; n_perr = 0; n_tmo = 0; n_busy = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clks(3);
        n_cmp++;
        if (data !== '0) begin n_bad++; $display("FAIL reset_data got=%h want=0", data); end
        n_cmp++;
        if ({stb, ferr, perr, tmo, busy} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags got=%b want=00000", {stb, ferr, perr, tmo, busy});
        end
        rst = 1'b0;
        clks(2);
    endtask

    task automatic test_short();
        clear_counts();
        div = 16'd10; par = 2'b00; stop2 = 1'b0;
        exp_q.push_back(40'h11_00000000);
        send_word(8'h11, 1'b0);
        clks(5);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL short_stb_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [OUT-1:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL short_data got=%h want=%h", g, e); end
        end
        n_cmp++;
        if (n_ferr + n_perr + n_tmo != 0) begin
            n_bad++; $display("FAIL short_errors got=%0d want=0", n_ferr + n_perr + n_tmo);
        end
    endtask

    task automatic test_long_even();
        logic [7:0] bytes[5];
        clear_counts();
        div = 16'd10; par = 2'b10; stop2 = 1'b0;
        bytes = '{8'h80, 8'h01, 8'h02, 8'h03, 8'h04};
        exp_q.push_back(40'h80_01020304);
        for (int i = 0; i < 5; i++) send_word(bytes[i], 1'b0);
        clks(5);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL long_stb_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [OUT-1:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL long_data got=%h want=%h", g, e); end
        end
        n_cmp++;
        if (n_ferr + n_perr != 0) begin
            n_bad++; $display("FAIL long_errors got=%0d want=0", n_ferr + n_perr);
        end
    endtask

    task automatic test_parity_err();
        clear_counts();
        div = 16'd10; par = 2'b01; stop2 = 1'b1;
        send_word(8'h80, 1'b1);
        clks(3);
        n_cmp++;
        if (n_perr != 1) begin n_bad++; $display("FAIL parity_err_count got=%0d want=1", n_perr); end
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++; $display("FAIL parity_bad_stb got=%0d want=0", got_q.size());
        end
        exp_q.push_back(40'h81_00000000);
        send_word(8'h81, 1'b0);
        for (int i = 0; i < 4; i++) send_word(8'h00, 1'b0);
        clks(5);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL parity_next_stb got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [OUT-1:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL parity_next_data got=%h want=%h", g, e); end
        end
        n_cmp++;
        if (n_perr != 1 || n_ferr != 0) begin
            n_bad++; $display("FAIL parity_total got=p%0d/f%0d want=p1/f0", n_perr, n_ferr);
        end
    endtask

    task automatic test_false_start_break();
        clear_counts();
        div = 16'd10; par = 2'b00; stop2 = 1'b0;
        rx = 1'b0;
        clks(3);
        rx = 1'b1;
        clks(20);
        n_cmp++;
        if (n_busy > 5) begin n_busy = n_busy; n_bad++; $display("FAIL glitch_busy_cycles got=%0d want<=5", n_busy); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_end got=%b want=0", busy); end
        n_cmp++;
        if (n_ferr + n_perr + n_tmo != 0 || got_q.size() != 0) begin
            n_bad++; $display("FAIL glitch_pulses got=%0d want=0", n_ferr + n_perr + n_tmo + got_q.size());
        end
        rx = 1'b0;
        clks(400);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL break_busy got=%b want=1", busy); end
        rx = 1'b1;
        clks(3);
        n_cmp++;
        if (n_ferr != 1) begin n_bad++; $display("FAIL break_ferr_count got=%0d want=1", n_ferr); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL break_release got=%b want=0", busy); end
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL break_stb got=%0d want=0", got_q.size()); end
        clks(20);
    endtask

    task automatic test_timeout();
        clear_counts();
        div = 16'd10; par = 2'b00; stop2 = 1'b0;
        send_word(8'h80, 1'b0);
        send_word(8'h01, 1'b0);
        clks(250);
        n_cmp++;
        if (n_tmo != 1) begin n_bad++; $display("FAIL timeout_count got=%0d want=1", n_tmo); end
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL timeout_stb got=%0d want=0", got_q.size()); end
        exp_q.push_back(40'h11_00000000);
        send_word(8'h11, 1'b0);
        clks(5);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL timeout_next_stb got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [OUT-1:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL timeout_next_data got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bytes[5];
        clear_counts();
        div = 16'd10; par = 2'b00; stop2 = 1'b0;
        send_word(8'h80, 1'b0);
        send_word(8'h01, 1'b0);
        send_word(8'h02, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        clks(2);
        n_cmp++;
        if (data !== '0 || {stb, ferr, perr, tmo, busy} !== 5'b0) begin
            n_bad++; $display("FAIL midreset_outputs got=%h/%b want=0/00000", data, {stb, ferr, perr, tmo, busy});
        end
        rx = 1'b1;
        rst = 1'b0;
        clks(30);
        bytes = '{8'h82, 8'h10, 8'h20, 8'h30, 8'h40};
        exp_q.push_back(40'h82_10203040);
        for (int i = 0; i < 5; i++) send_word(bytes[i], 1'b0);
        clks(5);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL midreset_stb got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [OUT-1:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL midreset_data got=%h want=%h", g, e); end
        end
        n_cmp++;
        if (n_ferr + n_perr + n_tmo != 0) begin
            n_bad++; $display("FAIL midreset_errors got=%0d want=0", n_ferr + n_perr + n_tmo);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_short();
        test_long_even();
        test_parity_err();
        test_false_start_break();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
